// File: rtl/fdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdc_pkg
// Description : Shared types, address map and decode helper for the FDC bus
//               front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    COMMIT  = 2'd2,
    STRETCH = 2'd3
  } fdc_bus_state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CTRL = 2'd1,
    WD   = 2'd2
  } fdc_kind_t;

  localparam logic [15:0] FDC_CTRL_BASE = 16'hFF40;
  localparam logic [15:0] FDC_WD_BASE   = 16'hFF48;

  // FF40-FF47 is the control register (mirrored), FF48-FF4B the WD1793.
  function automatic fdc_kind_t fdc_decode(input logic en, input logic [15:0] addr);
    fdc_decode = NONE;
    if (en && (addr[15:3] == FDC_CTRL_BASE[15:3])) begin
      fdc_decode = CTRL;
    end else if (en && (addr[15:2] == FDC_WD_BASE[15:2])) begin
      fdc_decode = WD;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdc_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : fdc_sync_edge
// Description : Two-flop synchronizer with one-cycle rise/fall pulses taken
//               from the synchronized level.
// Revision    : 1.0 - initial release
// ============================================================================
module fdc_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // s_q[1:0] is the synchronizer proper; s_q[2] is the edge-detect history.
  logic [2:0] s_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q <= 3'b000;
    end else begin
      s_q <= {s_q[1:0], d_i};
    end
  end

  assign rise_o =  s_q[1] & ~s_q[2];
  assign fall_o = ~s_q[1] &  s_q[2];

endmodule
`default_nettype wire

// File: rtl/fdc_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : fdc_bus_if
// Description : 6809 bus front end for the floppy controller: decodes the
//               FF40-FF4B window and generates the FDC strobes. Define
//               FDC_ACCESS_CNT_EN to build the WD1793 access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fdc_bus_if
  import fdc_pkg::*;
#(
  parameter int STRETCH_LEN    = 8,
  parameter int FF40_PULSE_LEN = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DISK_EN,
  input  logic        CPU_E,
  input  logic        CPU_RW,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DIN,
  output logic [7:0]  CPU_DOUT,
  output logic        CPU_DOUT_OE,
  input  logic [7:0]  FDC_DATA,
  output logic [1:0]  FDC_ADDR,
  output logic [7:0]  FDC_DIN,
  output logic        FF40_CLK,
  output logic        FF40_ENA,
  output logic        FF40_RD,
  output logic        WD1793_RD,
  output logic        WD1793_RD_CTRL,
  output logic        WD1793_WR_CTRL,
  output logic [15:0] ACC_CNT_RD,
  output logic [15:0] ACC_CNT_WR
);

  localparam logic [3:0] c_STRETCH_LEN = 4'(STRETCH_LEN);
  localparam logic [2:0] c_PULSE_LEN   = 3'(FF40_PULSE_LEN);

  logic w_e_rise;
  logic w_e_fall;

  fdc_sync_edge u_e_sync (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .d_i    (CPU_E),
    .rise_o (w_e_rise),
    .fall_o (w_e_fall)
  );

  // Bus fields delayed two cycles so they line up with the synchronized E.
  logic [24:0] bus_p1_q;
  logic [24:0] bus_p2_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus_p1_q <= '0;
      bus_p2_q <= '0;
    end else begin
      bus_p1_q <= {CPU_RW, CPU_ADDR, CPU_DIN};
      bus_p2_q <= bus_p1_q;
    end
  end

  logic        w_rw;
  logic [15:0] w_addr;
  logic [7:0]  w_din;
  fdc_kind_t   w_kind;

  assign {w_rw, w_addr, w_din} = bus_p2_q;
  assign w_kind = fdc_decode(DISK_EN, w_addr);

  fdc_bus_state_t state_q;
  fdc_kind_t      kind_q;
  logic           rw_q;
  logic [7:0]     din_hold_q;
  logic [7:0]     dout_q;
  logic           oe_q;
  logic [1:0]     fdc_addr_q;
  logic [7:0]     fdc_din_q;
  logic           ff40_clk_q;
  logic           ff40_ena_q;
  logic           ff40_rd_q;
  logic           wd_rd_q;
  logic           rd_ctrl_q;
  logic           wr_ctrl_q;
  logic [3:0]     scnt_q;
  logic [2:0]     pcnt_q;

  logic w_take;
  logic w_rd_launch;
  logic w_wr_launch;
  logic w_ctrl_wr;
  logic w_quiet;

  assign w_take      = w_e_rise && (w_kind != NONE) &&
                       ((state_q == IDLE) || (state_q == STRETCH));
  assign w_rd_launch = w_take && w_rw && (w_kind == WD);
  assign w_wr_launch = (state_q == COMMIT) && !rw_q && (kind_q == WD);
  assign w_ctrl_wr   = (state_q == COMMIT) && !rw_q && (kind_q == CTRL);
  assign w_quiet     = !rd_ctrl_q && !wr_ctrl_q && ff40_clk_q && !ff40_ena_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      kind_q     <= NONE;
      rw_q       <= 1'b1;
      din_hold_q <= 8'h00;
      dout_q     <= 8'h00;
      oe_q       <= 1'b0;
      fdc_addr_q <= 2'd0;
      fdc_din_q  <= 8'h00;
      ff40_clk_q <= 1'b1;
      ff40_ena_q <= 1'b0;
      ff40_rd_q  <= 1'b0;
      wd_rd_q    <= 1'b0;
      rd_ctrl_q  <= 1'b0;
      wr_ctrl_q  <= 1'b0;
      scnt_q     <= 4'd0;
      pcnt_q     <= 3'd0;
    end else begin
      // Strobe timers run independently of the state so a read strobe can
      // expire while E is still high.
      if (rd_ctrl_q || wr_ctrl_q) begin
        if (scnt_q == c_STRETCH_LEN) begin
          rd_ctrl_q <= 1'b0;
          wr_ctrl_q <= 1'b0;
        end else begin
          scnt_q <= scnt_q + 4'd1;
        end
      end

      if (!ff40_clk_q) begin
        if (pcnt_q == c_PULSE_LEN) begin
          ff40_clk_q <= 1'b1;
        end else begin
          pcnt_q <= pcnt_q + 3'd1;
        end
      end else if (ff40_ena_q) begin
        ff40_ena_q <= 1'b0;
      end

      case (state_q)
        IDLE, STRETCH: begin
          if ((state_q == STRETCH) && w_quiet) begin
            state_q <= IDLE;
          end
          if (w_take) begin
            // A new access cuts any pulse still in flight.
            rd_ctrl_q  <= 1'b0;
            wr_ctrl_q  <= 1'b0;
            ff40_clk_q <= 1'b1;
            ff40_ena_q <= 1'b0;
            kind_q     <= w_kind;
            rw_q       <= w_rw;
            fdc_addr_q <= w_addr[1:0];
            state_q    <= ACCESS;
            if (w_rd_launch) begin
              wd_rd_q   <= 1'b1;
              rd_ctrl_q <= 1'b1;
              scnt_q    <= 4'd1;
            end
            if (w_rw && (w_kind == CTRL)) begin
              ff40_rd_q <= 1'b1;
            end
          end
        end

        ACCESS: begin
          if (rw_q) begin
            dout_q <= FDC_DATA;
            oe_q   <= 1'b1;
          end else if (!w_e_fall) begin
            // Capture write data only while E is still high; the CPU may
            // release the bus right after E falls.
            din_hold_q <= w_din;
          end
          if (w_e_fall) begin
            state_q <= COMMIT;
          end
        end

        COMMIT: begin
          oe_q      <= 1'b0;
          ff40_rd_q <= 1'b0;
          wd_rd_q   <= 1'b0;
          if (!rw_q) begin
            fdc_din_q <= din_hold_q;
          end
          if (w_wr_launch) begin
            wr_ctrl_q <= 1'b1;
            scnt_q    <= 4'd1;
          end
          if (w_ctrl_wr) begin
            ff40_ena_q <= 1'b1;
            ff40_clk_q <= 1'b0;
            pcnt_q     <= 3'd1;
          end
          state_q <= (!rw_q || rd_ctrl_q) ? STRETCH : IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign CPU_DOUT       = dout_q;
  assign CPU_DOUT_OE    = oe_q;
  assign FDC_ADDR       = fdc_addr_q;
  assign FDC_DIN        = fdc_din_q;
  assign FF40_CLK       = ff40_clk_q;
  assign FF40_ENA       = ff40_ena_q;
  assign FF40_RD        = ff40_rd_q;
  assign WD1793_RD      = wd_rd_q;
  assign WD1793_RD_CTRL = rd_ctrl_q;
  assign WD1793_WR_CTRL = wr_ctrl_q;

`ifdef FDC_ACCESS_CNT_EN
  logic [15:0] acc_rd_q;
  logic [15:0] acc_wr_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_rd_q <= 16'd0;
      acc_wr_q <= 16'd0;
    end else begin
      if (w_rd_launch) acc_rd_q <= acc_rd_q + 16'd1;
      if (w_wr_launch) acc_wr_q <= acc_wr_q + 16'd1;
    end
  end

  assign ACC_CNT_RD = acc_rd_q;
  assign ACC_CNT_WR = acc_wr_q;
`else
  assign ACC_CNT_RD = 16'd0;
  assign ACC_CNT_WR = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fdc_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdc_bus_if
// Description : Scoreboard bench for fdc_bus_if: stimulus pushes expected
//               strobe/read events, a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdc_bus_if;

  localparam int EV_WR   = 0;
  localparam int EV_RD   = 1;
  localparam int EV_FF40 = 2;
  localparam int EV_READ = 3;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DISK_EN = 1'b1;
  logic        CPU_E = 1'b0;
  logic        CPU_RW = 1'b1;
  logic [15:0] CPU_ADDR = 16'h0000;
  logic [7:0]  CPU_DIN = 8'h00;
  logic [7:0]  FDC_DATA = 8'h00;
  logic [7:0]  CPU_DOUT;
  logic        CPU_DOUT_OE;
  logic [1:0]  FDC_ADDR;
  logic [7:0]  FDC_DIN;
  logic        FF40_CLK;
  logic        FF40_ENA;
  logic        FF40_RD;
  logic        WD1793_RD;
  logic        WD1793_RD_CTRL;
  logic        WD1793_WR_CTRL;
  logic [15:0] ACC_CNT_RD;
  logic [15:0] ACC_CNT_WR;

  fdc_bus_if dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .DISK_EN        (DISK_EN),
    .CPU_E          (CPU_E),
    .CPU_RW         (CPU_RW),
    .CPU_ADDR       (CPU_ADDR),
    .CPU_DIN        (CPU_DIN),
    .CPU_DOUT       (CPU_DOUT),
    .CPU_DOUT_OE    (CPU_DOUT_OE),
    .FDC_DATA       (FDC_DATA),
    .FDC_ADDR       (FDC_ADDR),
    .FDC_DIN        (FDC_DIN),
    .FF40_CLK       (FF40_CLK),
    .FF40_ENA       (FF40_ENA),
    .FF40_RD        (FF40_RD),
    .WD1793_RD      (WD1793_RD),
    .WD1793_RD_CTRL (WD1793_RD_CTRL),
    .WD1793_WR_CTRL (WD1793_WR_CTRL),
    .ACC_CNT_RD     (ACC_CNT_RD),
    .ACC_CNT_WR     (ACC_CNT_WR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int kind;
    int width;
    int aux;
    int addr;
    int data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_rd_cnt = 0;
  int  exp_wr_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int w, input int aux, input int a, input int d);
    ev_t e;
    e.kind = k; e.width = w; e.aux = aux; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d width %0d addr %0d data 0x%0h, expected none",
               got.kind, got.width, got.addr, got.data);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", got.kind, e.kind);
      if (e.width >= 0) chk("ev_width", got.width, e.width);
      chk("ev_aux", got.aux, e.aux);
      chk("ev_addr", got.addr, e.addr);
      chk("ev_data", got.data, e.data);
    end
  endtask

  // Monitor: measures pulse widths at negedge and emits one event per pulse.
  int wr_w = 0, rd_w = 0, lo_w = 0, ena_w = 0, oe_w = 0;
  int saw_wdrd = 0, saw_ffrd = 0, last_dout = 0;

  always @(negedge CLK) begin
    ev_t g;
    if (RESET) begin
      wr_w = 0; rd_w = 0; lo_w = 0; ena_w = 0; oe_w = 0;
      saw_wdrd = 0; saw_ffrd = 0;
    end else begin
      if (WD1793_WR_CTRL) wr_w++;
      else if (wr_w > 0) begin
        g.kind = EV_WR; g.width = wr_w; g.aux = 0; g.addr = int'(FDC_ADDR); g.data = int'(FDC_DIN);
        observe(g);
        wr_w = 0;
      end
      if (WD1793_RD_CTRL) rd_w++;
      else if (rd_w > 0) begin
        g.kind = EV_RD; g.width = rd_w; g.aux = 0; g.addr = int'(FDC_ADDR); g.data = 0;
        observe(g);
        rd_w = 0;
      end
      if (!FF40_CLK) lo_w++;
      if (FF40_ENA) ena_w++;
      else if (ena_w > 0) begin
        g.kind = EV_FF40; g.width = lo_w; g.aux = ena_w; g.addr = int'(FDC_ADDR); g.data = int'(FDC_DIN);
        observe(g);
        lo_w = 0; ena_w = 0;
      end
      if (CPU_DOUT_OE) begin
        oe_w++;
        last_dout = int'(CPU_DOUT);
        if (WD1793_RD) saw_wdrd = 1;
        if (FF40_RD) saw_ffrd = 1;
      end else if (oe_w > 0) begin
        g.kind = EV_READ; g.width = oe_w; g.aux = saw_wdrd * 2 + saw_ffrd;
        g.addr = int'(FDC_ADDR); g.data = last_dout;
        observe(g);
        oe_w = 0; saw_wdrd = 0; saw_ffrd = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // One 6809 cycle: ~28 CLK cycles E-high, ~32 E-low.
  task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] d);
    CPU_ADDR = a; CPU_RW = rw; CPU_DIN = d;
    tick(4);
    CPU_E = 1'b1;
    tick(28);
    CPU_E = 1'b0;
    tick(28);
  endtask

  task automatic bump_wr();
`ifdef FDC_ACCESS_CNT_EN
    exp_wr_cnt++;
`endif
  endtask

  task automatic bump_rd();
`ifdef FDC_ACCESS_CNT_EN
    exp_rd_cnt++;
`endif
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_dout"}, int'(CPU_DOUT), 0);
    chk({tag, "_cpu_dout_oe"}, int'(CPU_DOUT_OE), 0);
    chk({tag, "_fdc_addr"}, int'(FDC_ADDR), 0);
    chk({tag, "_fdc_din"}, int'(FDC_DIN), 0);
    chk({tag, "_ff40_clk"}, int'(FF40_CLK), 1);
    chk({tag, "_ff40_ena"}, int'(FF40_ENA), 0);
    chk({tag, "_ff40_rd"}, int'(FF40_RD), 0);
    chk({tag, "_wd_rd"}, int'(WD1793_RD), 0);
    chk({tag, "_rd_ctrl"}, int'(WD1793_RD_CTRL), 0);
    chk({tag, "_wr_ctrl"}, int'(WD1793_WR_CTRL), 0);
    chk({tag, "_acc_rd"}, int'(ACC_CNT_RD), 0);
    chk({tag, "_acc_wr"}, int'(ACC_CNT_WR), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 500000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    check_reset_values("reset");
    RESET = 1'b0;
    tick(2);

    // Control register write
    push(EV_FF40, 2, 3, 0, 8'hA9);
    access(16'hFF40, 1'b0, 8'hA9);

    // WD data register write
    push(EV_WR, 8, 0, 3, 8'h5C);
    bump_wr();
    access(16'hFF4B, 1'b0, 8'h5C);
    chk("acc_cnt_wr_after_write", int'(ACC_CNT_WR), exp_wr_cnt);

    // WD status read
    FDC_DATA = 8'h03;
    push(EV_RD, 8, 0, 0, 0);
    push(EV_READ, -1, 2, 0, 8'h03);
    bump_rd();
    access(16'hFF48, 1'b1, 8'h00);
    chk("acc_cnt_rd_after_read", int'(ACC_CNT_RD), exp_rd_cnt);

    // Control register read through its mirror
    FDC_DATA = 8'h3C;
    push(EV_READ, -1, 1, 0, 8'h3C);
    access(16'hFF44, 1'b1, 8'h00);

    // Outside the window: nothing at all
    access(16'hFF4C, 1'b1, 8'h00);
    chk("no_event_ff4c", exp_q.size(), 0);

    // Back-to-back WD writes
    push(EV_WR, 8, 0, 1, 8'h11);
    push(EV_WR, 8, 0, 2, 8'h22);
    bump_wr();
    bump_wr();
    access(16'hFF49, 1'b0, 8'h11);
    access(16'hFF4A, 1'b0, 8'h22);
    chk("acc_cnt_wr_b2b", int'(ACC_CNT_WR), exp_wr_cnt);

    // Cartridge disabled: decode blocked, latches hold
    DISK_EN = 1'b0;
    access(16'hFF48, 1'b0, 8'h99);
    chk("disabled_fdc_din_hold", int'(FDC_DIN), 8'h22);
    chk("disabled_fdc_addr_hold", int'(FDC_ADDR), 2);
    chk("disabled_no_event", exp_q.size(), 0);
    DISK_EN = 1'b1;

    // Reset while a write strobe is stretching
    CPU_ADDR = 16'hFF48; CPU_RW = 1'b0; CPU_DIN = 8'h77;
    tick(4);
    CPU_E = 1'b1;
    tick(28);
    CPU_E = 1'b0;
    tick(6);
    chk("wr_ctrl_mid_stretch", int'(WD1793_WR_CTRL), 1);
    RESET = 1'b1;
    tick(1);
    check_reset_values("mid_reset");
    RESET = 1'b0;
    exp_wr_cnt = 0;
    exp_rd_cnt = 0;
    tick(20);

    // Recovery after reset
    push(EV_WR, 8, 0, 0, 8'h3E);
    bump_wr();
    access(16'hFF48, 1'b0, 8'h3E);
    chk("acc_cnt_wr_after_reset", int'(ACC_CNT_WR), exp_wr_cnt);

    tick(10);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fdc_bus_if.md
Name: fdc_bus_if

Overview:
- CPU-side bus front end for the floppy disk controller.
- Samples the 6809 bus (E, R/W, address, write data) in the CLK domain and decodes the disk window.
- Produces the strobes the FDC consumes: FF40_CLK/FF40_ENA, FF40_RD, WD1793_RD, WD1793_WR_CTRL, WD1793_RD_CTRL, 2-bit register address and latched write data.
- Returns the FDC read data (DATA_HDD) to the CPU with an output enable.

Parameters:
- STRETCH_LEN, 8: CLK cycles that WD1793_WR_CTRL/WD1793_RD_CTRL stay high after launch; legal range 4..12.
- FF40_PULSE_LEN, 2: CLK cycles FF40_CLK is held low per control-register write; legal range 1..4.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DISK_EN  in  1  disk cartridge present/enabled; 0 blocks all decode.
- CPU_E  in  1  6809 E clock level, asynchronous to CLK.
- CPU_RW  in  1  1=read, 0=write.
- CPU_ADDR  in  16  CPU address.
- CPU_DIN  in  8  CPU write data.
- CPU_DOUT  out  8  read data to CPU.
- CPU_DOUT_OE  out  1  drive CPU_DOUT onto the CPU bus.
- FDC_DATA  in  8  FDC read mux output (DATA_HDD).
- FDC_ADDR  out  2  WD1793 register select.
- FDC_DIN  out  8  latched write data.
- FF40_CLK  out  1  control-register clock; FDC latches on its falling edge.
- FF40_ENA  out  1  control-register write qualifier.
- FF40_RD  out  1  control-register read select.
- WD1793_RD  out  1  WD1793 read select for the data mux.
- WD1793_RD_CTRL  out  1  stretched WD1793 read strobe.
- WD1793_WR_CTRL  out  1  stretched WD1793 write strobe.
- ACC_CNT_RD  out  16  WD1793 read count.
- ACC_CNT_WR  out  16  WD1793 write count.

Behaviour:
- Reset values: CPU_DOUT=0, CPU_DOUT_OE=0, FDC_ADDR=0, FDC_DIN=0, FF40_CLK=1, FF40_ENA=0, FF40_RD=0, WD1793_RD=0, WD1793_RD_CTRL=0, WD1793_WR_CTRL=0, counters=0, state=IDLE, synchronizers cleared. Reset mid-access forces these values on the next CLK edge.
- Input capture: CPU_E passes through a 2-flop synchronizer. CPU_RW, CPU_ADDR and CPU_DIN pass through a matching 2-stage delay so they stay aligned with the synchronized E. Edge detect produces e_rise and e_fall (each one cycle).
- Decode, with DISK_EN=1: CPU_ADDR[15:3]=$FF40>>3 (FF40-FF47) selects CTRL; CPU_ADDR[15:2]=$FF48>>2 (FF48-FF4B) selects WD; anything else selects none.
- FSM states: IDLE, ACCESS, COMMIT, STRETCH.
- IDLE:
  - On e_rise with a decode hit, latch kind (CTRL/WD), rw, and FDC_ADDR<=ADDR[1:0]; go to ACCESS.
  - Read+WD: WD1793_RD=1 and WD1793_RD_CTRL=1, launching the stretch counter immediately.
  - Read+CTRL: FF40_RD=1.
- ACCESS:
  - Reads: CPU_DOUT<=FDC_DATA every cycle; CPU_DOUT_OE=1.
  - On e_fall, go to COMMIT.
- COMMIT (one cycle):
  - Write+WD: FDC_DIN<=delayed CPU_DIN, WD1793_WR_CTRL<=1, stretch counter loads.
  - Write+CTRL: FDC_DIN<=delayed CPU_DIN, FF40_ENA<=1, FF40_CLK<=0 for FF40_PULSE_LEN cycles, then FF40_CLK<=1. FF40_ENA drops one cycle after FF40_CLK returns to 1.
  - Reads: CPU_DOUT_OE<=0, FF40_RD<=0, WD1793_RD<=0.
  - Go to STRETCH if a stretch or pulse is still running, else IDLE.
- STRETCH: when the counter reaches STRETCH_LEN and FF40_CLK=1 with FF40_ENA=0, drop all controls and go to IDLE.
- Read strobe width: WD1793_RD_CTRL is high for exactly STRETCH_LEN cycles from launch, whether that ends in ACCESS or STRETCH.
- Once-per-access rule: exactly one WD1793_RD_CTRL or WD1793_WR_CTRL rising edge per CPU access. This guarantees one status read clears INTRQ once and one data write advances the sector pointer once.
- e_rise while in STRETCH: controls drop that cycle and the new access is taken the same cycle, as in IDLE.
- e_rise with no decode hit: stays IDLE; no output changes.
- DISK_EN falling mid-access: the access completes normally; decode is blocked from the next e_rise.
- FDC_DIN and FDC_ADDR hold their values until the next decoded access.

Optional Feature:
- Macro: FDC_ACCESS_CNT_EN.
- Defined: ACC_CNT_RD increments on each WD1793_RD_CTRL launch; ACC_CNT_WR increments on each WD1793_WR_CTRL launch. Both are 16-bit, wrap at $FFFF->0, and are reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package fdc_pkg holds:
  - state enum fdc_bus_state_t (IDLE, ACCESS, COMMIT, STRETCH);
  - access kind enum (NONE, CTRL, WD);
  - address constants FDC_CTRL_BASE=$FF40 and FDC_WD_BASE=$FF48.
- Sub-module fdc_sync_edge: 2-flop synchronizer with rise/fall pulse outputs; instantiated for CPU_E.

Test Plan:
- Write $FF40<=$A9: FF40_CLK low 2 cycles, FF40_ENA high spanning it, FDC_DIN=$A9, no WD strobes.
- Write $FF4B<=$5C: one WD1793_WR_CTRL pulse of 8 cycles, FDC_ADDR=3, FDC_DIN=$5C; ACC_CNT_WR goes 0->1 when FDC_ACCESS_CNT_EN is defined.
- Read $FF48 with FDC_DATA=$03: WD1793_RD and CPU_DOUT_OE high through E-high, CPU_DOUT=$03, one 8-cycle WD1793_RD_CTRL.
- Read $FF44 (CTRL mirror): FF40_RD=1 during access, FDC_ADDR=0, no WD1793_RD_CTRL; read $FF4C: no strobe at all.
- Back-to-back WD writes at 1.79 MHz E: exactly 2 WR_CTRL pulses; RESET asserted mid-STRETCH clears all outputs to reset values next cycle.
- DISK_EN=0, write $FF48: no outputs change.
